// File: rtl/delta_modulator_if.sv
// Comparator-side and bit-stream-side signals of the delta modulator.
// The master side (the modulator) consumes comp and drives the estimate and status.
interface delta_modulator_if #(
  parameter int WIDTH = 8
);
  logic             comp;
  logic [WIDTH-1:0] result;
  logic             bit_out;
  logic [WIDTH-1:0] step;
  logic             update;
  logic             sat;

  modport master (input comp, output result, bit_out, step, update, sat);
  modport slave  (output comp, input result, bit_out, step, update, sat);
endinterface

// File: rtl/delta_modulator.sv
// Single-bit delta modulator tracking loop with update-rate divider and
// optional CVSD-style adaptive step.
module delta_modulator #(
  parameter int WIDTH    = 8,
  parameter int STEP_MIN = 1,
  parameter int STEP_MAX = 16,
  parameter int ADAPTIVE = 0,
  parameter int CLK_DIV  = 1
) (
  input  logic               clk_in,
  input  logic               reset,
  delta_modulator_if.master  bus
);

  localparam int               CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [WIDTH-1:0] STEP_MIN_W = WIDTH'(STEP_MIN);
  localparam logic [WIDTH-1:0] STEP_MAX_W = WIDTH'(STEP_MAX);

  // Returns {clamped, value}; the sum is formed one bit wider so it never wraps.
  function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] s);
    logic [WIDTH:0] sum;
    sum = {1'b0, r} + {1'b0, s};
    return sum[WIDTH] ? {1'b1, {WIDTH{1'b1}}} : {1'b0, sum[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] s);
    logic signed [WIDTH:0] diff;
    diff = $signed({1'b0, r}) - $signed({1'b0, s});
    return (diff < 0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, diff[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH-1:0] step_grow(input logic [WIDTH-1:0] s);
    logic [WIDTH:0] dbl;
    dbl = {s, 1'b0};
    return (dbl > {1'b0, STEP_MAX_W}) ? STEP_MAX_W : dbl[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] step_shrink(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] half;
    half = s >> 1;
    return (half < STEP_MIN_W) ? STEP_MIN_W : half;
  endfunction

  logic [CNT_W-1:0] div_cnt;
  logic [WIDTH-1:0] result_p1;
  logic [WIDTH-1:0] step_p1;
  logic             bit_p1;
  logic             sat_p1;
  logic             vld_p1;
  logic [1:0]       hist;
  logic [1:0]       hist_cnt;

  logic             vld_p0;
  logic [WIDTH:0]   next_p0;
  logic             run_p0;

  // Stage p0: update decision and clamped next estimate
  always_comb begin
    vld_p0  = (div_cnt == CNT_LAST);
    next_p0 = bus.comp ? step_up(result_p1, step_p1) : step_down(result_p1, step_p1);
    // Only bits captured since reset take part; a run needs at least one valid predecessor.
    run_p0  = (hist_cnt != 2'd0) && (bus.comp == hist[0]) &&
              ((hist_cnt == 2'd1) || (bus.comp == hist[1]));
  end

  // Stage p1: registered estimate, step and status
  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_cnt   <= '0;
      result_p1 <= '0;
      step_p1   <= STEP_MIN_W;
      bit_p1    <= 1'b0;
      sat_p1    <= 1'b0;
      vld_p1    <= 1'b0;
      hist      <= 2'b00;
      hist_cnt  <= 2'd0;
    end else begin
      div_cnt <= vld_p0 ? '0 : div_cnt + CNT_W'(1);
      vld_p1  <= vld_p0;
      sat_p1  <= 1'b0;
      if (vld_p0) begin
        result_p1 <= next_p0[WIDTH-1:0];
        sat_p1    <= next_p0[WIDTH];
        bit_p1    <= bus.comp;
        hist      <= {hist[0], bus.comp};
        if (hist_cnt != 2'd2) hist_cnt <= hist_cnt + 2'd1;
        if (ADAPTIVE != 0) step_p1 <= run_p0 ? step_grow(step_p1) : step_shrink(step_p1);
      end
    end
  end

  assign bus.result  = result_p1;
  assign bus.step    = step_p1;
  assign bus.bit_out = bit_p1;
  assign bus.sat     = sat_p1;
  assign bus.update  = vld_p1;

endmodule

// File: tb/tb_delta_modulator.sv
// Self-checking bench: four parameterisations of delta_modulator against a
// behavioural model, plus table-driven and hand-written directed sequences.
module tb_delta_modulator;

  localparam int ND = 4;
  localparam int P_MIN   [ND] = '{1, 4, 1, 1};
  localparam int P_MAX   [ND] = '{16, 16, 16, 16};
  localparam int P_ADAPT [ND] = '{0, 0, 0, 1};
  localparam int P_DIV   [ND] = '{1, 1, 4, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c [ND];

  always #5 clk = ~clk;

  delta_modulator_if #(.WIDTH(8)) if0 ();
  delta_modulator_if #(.WIDTH(8)) if1 ();
  delta_modulator_if #(.WIDTH(8)) if2 ();
  delta_modulator_if #(.WIDTH(8)) if3 ();

  delta_modulator #(.WIDTH(8), .STEP_MIN(1), .STEP_MAX(16), .ADAPTIVE(0), .CLK_DIV(1))
    dut0 (.clk_in(clk), .reset(rst), .bus(if0));
  delta_modulator #(.WIDTH(8), .STEP_MIN(4), .STEP_MAX(16), .ADAPTIVE(0), .CLK_DIV(1))
    dut1 (.clk_in(clk), .reset(rst), .bus(if1));
  delta_modulator #(.WIDTH(8), .STEP_MIN(1), .STEP_MAX(16), .ADAPTIVE(0), .CLK_DIV(4))
    dut2 (.clk_in(clk), .reset(rst), .bus(if2));
  delta_modulator #(.WIDTH(8), .STEP_MIN(1), .STEP_MAX(16), .ADAPTIVE(1), .CLK_DIV(1))
    dut3 (.clk_in(clk), .reset(rst), .bus(if3));

  assign if0.comp = c[0];
  assign if1.comp = c[1];
  assign if2.comp = c[2];
  assign if3.comp = c[3];

  logic [7:0] o_res [ND];
  logic [7:0] o_step[ND];
  logic       o_bit [ND];
  logic       o_upd [ND];
  logic       o_sat [ND];
  assign o_res[0] = if0.result;  assign o_step[0] = if0.step;  assign o_bit[0] = if0.bit_out;
  assign o_res[1] = if1.result;  assign o_step[1] = if1.step;  assign o_bit[1] = if1.bit_out;
  assign o_res[2] = if2.result;  assign o_step[2] = if2.step;  assign o_bit[2] = if2.bit_out;
  assign o_res[3] = if3.result;  assign o_step[3] = if3.step;  assign o_bit[3] = if3.bit_out;
  assign o_upd[0] = if0.update;  assign o_sat[0] = if0.sat;
  assign o_upd[1] = if1.update;  assign o_sat[1] = if1.sat;
  assign o_upd[2] = if2.update;  assign o_sat[2] = if2.sat;
  assign o_upd[3] = if3.update;  assign o_sat[3] = if3.sat;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept as plain integers.
  int m_res [ND], m_step[ND], m_bit[ND], m_upd[ND], m_sat[ND];
  int m_edges[ND], m_nbits[ND], m_last1[ND], m_last2[ND];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input int d, input bit r, input bit cv);
    int nxt;
    bit run;
    if (r) begin
      m_res[d] = 0; m_step[d] = P_MIN[d]; m_bit[d] = 0; m_upd[d] = 0; m_sat[d] = 0;
      m_edges[d] = 0; m_nbits[d] = 0; m_last1[d] = 0; m_last2[d] = 0;
      return;
    end
    if ((m_edges[d] % P_DIV[d]) == P_DIV[d] - 1) begin
      nxt = cv ? m_res[d] + m_step[d] : m_res[d] - m_step[d];
      m_sat[d] = (nxt > 255 || nxt < 0) ? 1 : 0;
      m_res[d] = (nxt > 255) ? 255 : (nxt < 0) ? 0 : nxt;
      if (P_ADAPT[d] != 0) begin
        run = (m_nbits[d] >= 1) && (cv == m_last1[d]) && (m_nbits[d] < 2 || cv == m_last2[d]);
        if (run) m_step[d] = (2 * m_step[d] > P_MAX[d]) ? P_MAX[d] : 2 * m_step[d];
        else     m_step[d] = (m_step[d] / 2 < P_MIN[d]) ? P_MIN[d] : m_step[d] / 2;
      end
      m_last2[d] = m_last1[d];
      m_last1[d] = cv;
      m_nbits[d]++;
      m_bit[d] = cv;
      m_upd[d] = 1;
    end else begin
      m_upd[d] = 0;
      m_sat[d] = 0;
    end
    m_edges[d]++;
  endtask

  task automatic tick(input bit r);
    rst = r;
    for (int d = 0; d < ND; d++) model(d, r, c[d]);
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dut%0d result", d), o_res[d], m_res[d]);
      check($sformatf("dut%0d step", d), o_step[d], m_step[d]);
      check($sformatf("dut%0d bit_out", d), o_bit[d], m_bit[d]);
      check($sformatf("dut%0d update", d), o_upd[d], m_upd[d]);
      check($sformatf("dut%0d sat", d), o_sat[d], m_sat[d]);
    end
  endtask

  task automatic set_all(input bit v);
    for (int d = 0; d < ND; d++) c[d] = v;
  endtask

  task automatic track(input int target);
    for (int d = 0; d < ND; d++) c[d] = (target > m_res[d]);
  endtask

  typedef struct {
    bit rst;
    bit comp;
    int res;
    int bitv;
    int upd;
    int sat;
  } vec_t;

  vec_t tbl [13];
  int   exp_ar [8] = '{1, 2, 4, 8, 16, 32, 48, 32};
  int   exp_as [8] = '{1, 2, 4, 8, 16, 16, 16, 8};

  initial begin
    // Directed vectors for the default configuration (dut0).
    tbl[0]  = '{1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 1, 0};
    tbl[4]  = '{0, 1, 2, 1, 1, 0};
    tbl[5]  = '{0, 0, 1, 0, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 1};
    tbl[8]  = '{0, 0, 0, 0, 1, 1};
    tbl[9]  = '{0, 1, 1, 1, 1, 0};
    tbl[10] = '{0, 1, 2, 1, 1, 0};
    tbl[11] = '{1, 1, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 1, 1, 1, 0};

    set_all(1'b1);
    for (int i = 0; i < 13; i++) begin
      set_all(tbl[i].comp);
      tick(tbl[i].rst);
      check($sformatf("vec%0d result", i), o_res[0], tbl[i].res);
      check($sformatf("vec%0d bit_out", i), o_bit[0], tbl[i].bitv);
      check($sformatf("vec%0d update", i), o_upd[0], tbl[i].upd);
      check($sformatf("vec%0d sat", i), o_sat[0], tbl[i].sat);
      check($sformatf("vec%0d step", i), o_step[0], 1);
    end

    // Adaptive ramp on dut3 and divider cadence on dut2.
    set_all(1'b1);
    tick(1'b1);
    for (int k = 1; k <= 8; k++) begin
      set_all(k <= 7);
      tick(1'b0);
      check($sformatf("adapt%0d result", k), o_res[3], exp_ar[k-1]);
      check($sformatf("adapt%0d step", k), o_step[3], exp_as[k-1]);
      check($sformatf("div%0d result", k), o_res[2], (k >= 4 && k <= 7) ? 1 : 0);
      check($sformatf("div%0d update", k), o_upd[2], (k == 4 || k == 8) ? 1 : 0);
    end

    // Overflow clamp with step 4 on dut1.
    tick(1'b1);
    set_all(1'b1);
    for (int k = 1; k <= 66; k++) begin
      tick(1'b0);
      if (k == 63) begin
        check("ovf pre result", o_res[1], 252);
        check("ovf pre sat", o_sat[1], 0);
      end
      if (k >= 64) begin
        check($sformatf("ovf%0d result", k), o_res[1], 255);
        check($sformatf("ovf%0d sat", k), o_sat[1], 1);
      end
    end

    // Closed-loop tracking on dut0: target 10, then 60, then 0, then 226.
    tick(1'b1);
    for (int k = 1; k <= 14; k++) begin
      track(10);
      tick(1'b0);
      check($sformatf("trk10 step%0d", k), o_res[0], (k <= 10) ? k : ((k % 2) ? 9 : 10));
    end
    for (int k = 1; k <= 50; k++) begin
      track(60);
      tick(1'b0);
    end
    check("trk60 result", o_res[0], 60);
    for (int k = 1; k <= 70; k++) begin
      track(0);
      tick(1'b0);
    end
    check("trk0 result", o_res[0], 0);
    check("trk0 sat", o_sat[0], 1);
    for (int k = 1; k <= 40; k++) begin
      track(226);
      tick(1'b0);
    end
    check("trk226 result", o_res[0], 40);

    // Random comparator bits, then run-biased bits, with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      for (int d = 0; d < ND; d++) c[d] = 1'($urandom_range(0, 1));
      tick($urandom_range(0, 199) == 0);
    end
    for (int k = 0; k < 1500; k++) begin
      for (int d = 0; d < ND; d++) if ($urandom_range(0, 5) == 0) c[d] = ~c[d];
      tick($urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
